// File: rtl/serializer_10b.sv
// serializer_10b
// Parallel-to-serial stage behind the 8b/10b encoder. It takes 10-bit code
// groups over a valid/ready handshake and sends them out MSB first (code bit
// 'a'), one bit per clock. Empty word slots are filled with an idle group.
// A single hold register buffers one word ahead of the shift register.
//
// Optional feature: define SER10B_IDLE_COMMA_EN to send K28.5 as the idle
// group, picking its polarity from the tracked link running disparity.
// Without the macro the idle group is IDLE_WORD and link_rd is tied low.
module serializer_10b #(
    parameter logic [9:0] IDLE_WORD = 10'b0101010101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       ser_out,
    output logic       word_start,
    output logic       idle,
    output logic       link_rd
);

    logic [9:0] r_shift;
    logic [9:0] r_hold;
    logic [3:0] r_bit_cnt;
    logic       r_hold_valid;
    logic       r_idle;

    logic       w_boundary;
    logic       w_accept;
    logic [9:0] w_idle_group;
    logic [9:0] w_load_group;

    // The last bit of a group is on the line when bit_cnt reaches 9; the
    // following posedge loads the next group.
    assign w_boundary   = (r_bit_cnt == 4'd9);
    assign w_accept     = din_valid && !r_hold_valid;
    assign w_load_group = r_hold_valid ? r_hold : w_idle_group;

`ifdef SER10B_IDLE_COMMA_EN
    logic r_link_rd;

    function automatic logic [3:0] f_popcount(input logic [9:0] grp);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 10; i++) begin
            cnt = cnt + {3'd0, grp[i]};
        end
        return cnt;
    endfunction

    // Running disparity follows every loaded group; balanced groups keep it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_link_rd <= 1'b0;
        end else if (w_boundary) begin
            if (f_popcount(w_load_group) > 4'd5) begin
                r_link_rd <= 1'b1;
            end else if (f_popcount(w_load_group) < 4'd5) begin
                r_link_rd <= 1'b0;
            end
        end
    end

    assign w_idle_group = r_link_rd ? 10'b1100000101 : 10'b0011111010;
    assign link_rd      = r_link_rd;
`else
    assign w_idle_group = IDLE_WORD;
    assign link_rd      = 1'b0;
`endif

    // Shift register, bit counter and buffer/idle flags; a reset aborts the
    // group in flight and drops any word waiting in the hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift      <= 10'd0;
            r_bit_cnt    <= 4'd9;
            r_hold_valid <= 1'b0;
            r_idle       <= 1'b0;
        end else begin
            if (w_boundary) begin
                r_shift   <= w_load_group;
                r_idle    <= !r_hold_valid;
                r_bit_cnt <= 4'd0;
            end else begin
                r_shift   <= {r_shift[8:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            // An accept wins over the drain: a word taken at a boundary with
            // an empty buffer waits for the next boundary.
            if (w_accept) begin
                r_hold_valid <= 1'b1;
            end else if (w_boundary) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    // Hold buffer data; its validity is tracked separately by r_hold_valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold <= din;
        end
    end

    assign din_ready  = !r_hold_valid;
    assign ser_out    = r_shift[9];
    assign word_start = (r_bit_cnt == 4'd0);
    assign idle       = r_idle;

endmodule

// File: tb/tb_serializer_10b.sv
// tb_serializer_10b
// Bench for serializer_10b: a line-level reference model (group slots every
// 10 clocks, a one-deep pending queue, popcount disparity), directed corner
// sequences, a table of phase/latency vectors and a randomized run.
// Honours SER10B_IDLE_COMMA_EN the same way as the design.
module tb_serializer_10b;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] din = 10'd0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       ser_out;
    logic       word_start;
    logic       idle;
    logic       link_rd;

    int checks   = 0;
    int failures = 0;

    serializer_10b dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .ser_out    (ser_out),
        .word_start (word_start),
        .idle       (idle),
        .link_rd    (link_rd)
    );

    always #5 clk = ~clk;

    // Reference model: m_t counts posedges since reset release; a new group
    // slot begins on posedges 1, 11, 21, ...
    int         m_t;
    logic [9:0] m_cur;
    bit         m_cur_idle;
    logic [9:0] m_q[$];
    bit         m_rd;
    bit         m_last_acc;

    function automatic logic [9:0] idle_group();
`ifdef SER10B_IDLE_COMMA_EN
        return m_rd ? 10'b1100000101 : 10'b0011111010;
`else
        return 10'b0101010101;
`endif
    endfunction

    function automatic int phase();
        return (m_t == 0) ? -1 : (m_t - 1) % 10;
    endfunction

    task automatic model_reset();
        m_t        = 0;
        m_cur      = 10'd0;
        m_cur_idle = 1'b0;
        m_rd       = 1'b0;
        m_q.delete();
    endtask

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic exp_ser, exp_ws, exp_idle;
        int   ph;
        ph = phase();
        if (ph < 0) begin
            exp_ser  = 1'b0;
            exp_ws   = 1'b0;
            exp_idle = 1'b0;
        end else begin
            exp_ser  = m_cur[9-ph];
            exp_ws   = (ph == 0);
            exp_idle = m_cur_idle;
        end
        chk("ser_out",    ser_out,    exp_ser);
        chk("word_start", word_start, exp_ws);
        chk("idle",       idle,       exp_idle);
        chk("din_ready",  din_ready,  m_q.size() == 0);
        chk("link_rd",    link_rd,    m_rd);
    endtask

    // One clock: sample handshake before the edge, advance model, check at negedge.
    task automatic step();
        bit         acc;
        logic [9:0] d;
        acc = din_valid && (m_q.size() == 0) && !rst;
        d   = din;
        @(posedge clk);
        m_last_acc = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            m_t++;
            if ((m_t - 1) % 10 == 0) begin
                if (m_q.size() > 0) begin
                    m_cur      = m_q.pop_front();
                    m_cur_idle = 1'b0;
                end else begin
                    m_cur      = idle_group();
                    m_cur_idle = 1'b1;
                end
`ifdef SER10B_IDLE_COMMA_EN
                if ($countones(m_cur) > 5)      m_rd = 1'b1;
                else if ($countones(m_cur) < 5) m_rd = 1'b0;
`endif
            end
            if (acc) begin
                m_q.push_back(d);
                m_last_acc = 1'b1;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        while (!(phase() == ph && m_q.size() == 0) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL wait_phase: phase %0d never reached (got %0d)", ph, phase());
        end
    endtask

    task automatic collect10(output logic [9:0] bits, output logic first_ws, output logic any_idle);
        bits     = 10'd0;
        first_ws = 1'b0;
        any_idle = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            bits = {bits[8:0], ser_out};
            if (i == 0) first_ws = word_start;
            if (idle) any_idle = 1'b1;
        end
    endtask

    typedef struct {
        logic [9:0] word;
        int         ph;       // phase (bits already sent) when valid is raised
        int         exp_lat;  // clocks from accept edge to the word's first bit
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [9:0] bits, wa, wb, w1, w2;
        logic [19:0] b20, exp20;
        logic       fws, anyi, idle_all, idle_seen, r_after;
        int         ws_cnt, lat;

        vecs[0] = '{10'b1010110001, 8, 1};
        vecs[1] = '{10'b0110101100, 0, 9};
        vecs[2] = '{10'b1100110010, 9, 10};
        vecs[3] = '{10'b0011100111, 5, 4};
        vecs[4] = '{10'b1011000110, 3, 6};

        model_reset();
        m_last_acc = 1'b0;

        // Reset held across edges
        repeat (3) step();
        chk("rst_ser_out", ser_out, 1'b0);
        chk("rst_ready",   din_ready, 1'b1);
        chk("rst_ws",      word_start, 1'b0);
        rst = 1'b0;

        // 1: idle stream after release
`ifdef SER10B_IDLE_COMMA_EN
        exp20 = {10'b0011111010, 10'b1100000101};
`else
        exp20 = {10'b0101010101, 10'b0101010101};
`endif
        b20 = 20'd0; idle_all = 1'b1; ws_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            b20 = {b20[18:0], ser_out};
            if (!idle) idle_all = 1'b0;
            if (word_start) ws_cnt++;
        end
        chk("t1_idle_stream", b20, exp20);
        chk("t1_idle_flag", idle_all, 1'b1);
        chk("t1_ws_count", ws_cnt[19:0], 20'd2);

        // 2: word presented one cycle before a boundary
        wait_phase(8);
        din = 10'b1001111011; din_valid = 1'b1;
        step();
        din_valid = 1'b0; din = 10'($urandom);
        chk("t2_ready_low", din_ready, 1'b0);
        collect10(bits, fws, anyi);
        chk("t2_bits", bits, 10'b1001111011);
        chk("t2_ws", fws, 1'b1);
        chk("t2_not_idle", anyi, 1'b0);

        // 3: back-to-back words with valid held high
        wa = 10'b1001111011; wb = 10'b0111011001;
        wait_phase(8);
        din = wa; din_valid = 1'b1;
        step();
        chk("t3_ready_low_A", din_ready, 1'b0);
        din = wb;
        b20 = 20'd0; idle_seen = 1'b0; r_after = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            b20 = {b20[18:0], ser_out};
            if (idle) idle_seen = 1'b1;
            if (i == 0) r_after = din_ready;
            if (m_last_acc) din_valid = 1'b0;
        end
        din_valid = 1'b0;
        exp20 = {wa, wb};
        chk("t3_stream", b20, exp20);
        chk("t3_no_gap", idle_seen, 1'b0);
        chk("t3_ready_back", r_after, 1'b1);

        // 4: word arrives in the boundary cycle with hold empty
        wait_phase(9);
        din = 10'b1110010010; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk("t4_idle_first", idle, 1'b1);
        chk("t4_ws", word_start, 1'b1);
        chk("t4_held", din_ready, 1'b0);
        repeat (9) step();
        collect10(bits, fws, anyi);
        chk("t4_bits", bits, 10'b1110010010);
        chk("t4_ws_10_later", fws, 1'b1);
        chk("t4_not_idle", anyi, 1'b0);

`ifdef SER10B_IDLE_COMMA_EN
        // 5: disparity through a popcount-4 word and the following idles
        begin
            int n;
            n = 0;
            while (!(phase() == 8 && m_q.size() == 0 && link_rd == 1'b0) && n < 40) begin
                step();
                n++;
            end
        end
        chk("t5_rd_start", link_rd, 1'b0);
        din = 10'b1100010100; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        collect10(bits, fws, anyi);
        chk("t5_bits", bits, 10'b1100010100);
        chk("t5_rd_after_word", link_rd, 1'b0);
        collect10(bits, fws, anyi);
        chk("t5_idle_rdm", bits, 10'b0011111010);
        chk("t5_rd_after_idle", link_rd, 1'b1);
        collect10(bits, fws, anyi);
        chk("t5_idle_rdp", bits, 10'b1100000101);
`endif

        // 5-entry table: phase of arrival vs. latency to first bit
        for (int v = 0; v < 5; v++) begin
            wait_phase(vecs[v].ph);
            din = vecs[v].word; din_valid = 1'b1;
            step();
            din_valid = 1'b0;
            lat = -1;
            for (int k = 1; k <= 20; k++) begin
                step();
                if (word_start && !idle) begin
                    lat = k;
                    break;
                end
            end
            chk("vec_latency", lat[19:0], vecs[v].exp_lat[19:0]);
            bits = {9'd0, ser_out};
            for (int k = 0; k < 9; k++) begin
                step();
                bits = {bits[8:0], ser_out};
            end
            chk("vec_bits", bits, vecs[v].word);
        end

        // 6: async reset at bit 4 of a data word with the hold buffer full
        w1 = 10'b0111101000; w2 = 10'b1110001100;
        wait_phase(8);
        din = w1; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        repeat (3) step();
        din = w2; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk("t6_hold_full", din_ready, 1'b0);
        chk("t6_mid_bit", ser_out, w1[5]);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("t6_rst_ser", ser_out, 1'b0);
        chk("t6_rst_ready", din_ready, 1'b1);
        chk("t6_rst_ws", word_start, 1'b0);
        chk("t6_rst_idle", idle, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("t6_restart_ws", word_start, 1'b1);
        chk("t6_restart_idle", idle, 1'b1);
        idle_all = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!idle) idle_all = 1'b0;
        end
        chk("t6_held_dropped", idle_all, 1'b1);

        // Randomized traffic with one reset in the middle
        for (int i = 0; i < 800; i++) begin
            din       = 10'($urandom);
            din_valid = ($urandom_range(0, 3) == 0);
            if (i == 400) begin
                #2 rst = 1'b1;
                #1 model_reset();
                step();
                rst = 1'b0;
            end
            step();
        end
        din_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
